emu_reset_tracker: RTL and testbench

EMU_RESET_TRACKER -- requirements
Module: emu_reset_tracker

---
 rtl/emu_reset_pkg.sv | 8 +
 rtl/emu_reset_evt_fifo.sv | 38 +++
 rtl/emu_reset_tracker.sv | 50 +++++
 tb/tb_emu_reset_tracker.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/emu_reset_pkg.sv
// emu_reset_pkg: shared constants and event type for the emulated-reset tracker
package emu_reset_pkg;
    localparam int EMU_RESET_CYCLE_WIDTH = 64;
    typedef struct packed {
        logic [EMU_RESET_CYCLE_WIDTH-1:0] cycle;
        logic                             level;
    } emu_reset_evt_t;
endpackage

// File: rtl/emu_reset_evt_fifo.sv
// emu_reset_evt_fifo: first-word-fall-through event FIFO with wrap-bit pointers
module emu_reset_evt_fifo
    import emu_reset_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push,
    input  emu_reset_evt_t push_data,
    input  logic           pop,
    output logic           head_valid,
    output emu_reset_evt_t head_data,
    output logic           full
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0] wr, rd;
    logic do_push, do_pop;
    emu_reset_evt_t mem [DEPTH];
    assign head_valid = wr != rd;
    assign full = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
    assign do_pop = pop && head_valid;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
    assign do_push = push && (!full || do_pop);
    assign head_data = mem[rd[AW-1:0]];
    always_ff @(posedge clk) begin
        if (rst) begin
            wr <= '0;
            rd <= '0;
        end else begin
            if (do_push) wr <= wr + (AW+1)'(1);
            if (do_pop) rd <= rd + (AW+1)'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push && !rst) mem[wr[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/emu_reset_tracker.sv
// emu_reset_tracker: timestamps level changes of an emulated reset into an event FIFO
module emu_reset_tracker
    import emu_reset_pkg::*;
#(
    parameter int CYCLE_WIDTH = 64,
    parameter int DEPTH       = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    input  logic                   target_reset,
    output logic [CYCLE_WIDTH-1:0] cycle,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic [CYCLE_WIDTH-1:0] evt_cycle,
    output logic                   evt_level,
    output logic                   overflow
);
    logic prev_level, edge_det, full, pop;
    emu_reset_evt_t push_data, head_data;
    assign edge_det = run && (target_reset != prev_level);
    assign pop = evt_valid && evt_ready;
    assign push_data = '{cycle: EMU_RESET_CYCLE_WIDTH'(cycle), level: target_reset};
    assign evt_cycle = head_data.cycle[CYCLE_WIDTH-1:0];
    assign evt_level = head_data.level;
    emu_reset_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (edge_det),
        .push_data (push_data),
        .pop       (pop),
        .head_valid(evt_valid),
        .head_data (head_data),
        .full      (full)
    );
    // The emulated design comes up in reset, so prev_level starts high
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle      <= '0;
            prev_level <= 1'b1;
            overflow   <= 1'b0;
        end else begin
            if (run) begin
                cycle      <= cycle + CYCLE_WIDTH'(1);
                prev_level <= target_reset;
            end
            if (edge_det && full && !pop) overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_emu_reset_tracker.sv
// tb_emu_reset_tracker: directed checks of event capture, FIFO behaviour, reset and wrap
module tb_emu_reset_tracker;
    localparam int CW = 8;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          run = 1'b0;
    logic          target_reset = 1'b1;
    logic          evt_ready = 1'b0;
    logic [CW-1:0] cycle, evt_cycle;
    logic          evt_valid, evt_level, overflow;
    int            n_cmp = 0;
    int            n_bad = 0;

    emu_reset_tracker #(.CYCLE_WIDTH(CW), .DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .target_reset(target_reset),
        .cycle       (cycle),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_cycle   (evt_cycle),
        .evt_level   (evt_level),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_evt(input string tag, input logic [CW-1:0] c, input logic l);
        check({tag, "_valid"}, 64'(evt_valid), 64'd1);
        check({tag, "_cycle"}, 64'(evt_cycle), 64'(c));
        check({tag, "_level"}, 64'(evt_level), 64'(l));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run = 1'b1;
        target_reset = 1'b0;
        evt_ready = 1'b0;
        step();
        rst = 1'b0;
        target_reset = 1'b1;
        check("rst_cycle", 64'(cycle), 64'd0);
        check("rst_valid", 64'(evt_valid), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
    endtask

    initial begin
        logic lv [13];
        // Startup release: single deassert event at cycle 20
        do_reset();
        repeat (20) step();
        check("start_cycle20", 64'(cycle), 64'd20);
        check("start_no_evt", 64'(evt_valid), 64'd0);
        target_reset = 1'b0;
        step();
        check_evt("start_evt", 8'd20, 1'b0);
        repeat (3) step();
        check_evt("start_hold", 8'd20, 1'b0);
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        repeat (3) step();
        check("start_only_one", 64'(evt_valid), 64'd0);

        // Gated run: toggles while run=0 must be invisible
        do_reset();
        run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            target_reset = ~i[0];
            step();
        end
        check("gate_cycle", 64'(cycle), 64'd0);
        check("gate_no_evt", 64'(evt_valid), 64'd0);
        run = 1'b1;
        target_reset = 1'b1;
        step();
        check("gate_cycle1", 64'(cycle), 64'd1);
        check("gate_still_none", 64'(evt_valid), 64'd0);

        // Backpressure: edges at 3,5,7,9,11 with DEPTH=4 drops the fifth
        do_reset();
        lv = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int c = 0; c < 13; c++) begin
            target_reset = lv[c];
            step();
        end
        check("bp_overflow", 64'(overflow), 64'd1);
        check_evt("bp_head", 8'd3, 1'b0);
        evt_ready = 1'b1;
        check_evt("bp_d0", 8'd3, 1'b0);
        step();
        check_evt("bp_d1", 8'd5, 1'b1);
        step();
        check_evt("bp_d2", 8'd7, 1'b0);
        step();
        check_evt("bp_d3", 8'd9, 1'b1);
        step();
        check("bp_empty", 64'(evt_valid), 64'd0);
        check("bp_ovf_sticky", 64'(overflow), 64'd1);
        evt_ready = 1'b0;

        // Full FIFO: push and pop in the same cycle both take effect
        do_reset();
        lv = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int c = 0; c < 6; c++) begin
            target_reset = lv[c];
            step();
        end
        check_evt("full_head", 8'd1, 1'b0);
        target_reset = 1'b0;
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        target_reset = 1'b0;
        check("full_no_ovf", 64'(overflow), 64'd0);
        check_evt("full_f0", 8'd2, 1'b1);
        evt_ready = 1'b1;
        step();
        check_evt("full_f1", 8'd3, 1'b0);
        step();
        check_evt("full_f2", 8'd4, 1'b1);
        step();
        check_evt("full_f3", 8'd6, 1'b0);
        step();
        check("full_empty", 64'(evt_valid), 64'd0);
        evt_ready = 1'b0;

        // Mid-stream reset discards buffered events
        do_reset();
        target_reset = 1'b1;
        step();
        target_reset = 1'b0;
        step();
        target_reset = 1'b1;
        step();
        check_evt("mid_buffered", 8'd1, 1'b0);
        evt_ready = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        evt_ready = 1'b0;
        target_reset = 1'b1;
        check("mid_valid", 64'(evt_valid), 64'd0);
        check("mid_cycle", 64'(cycle), 64'd0);
        check("mid_overflow", 64'(overflow), 64'd0);
        repeat (4) step();
        check("mid_quiet", 64'(evt_valid), 64'd0);
        target_reset = 1'b0;
        step();
        check_evt("mid_evt", 8'd4, 1'b0);

        // Wrap-around of the 8-bit cycle counter
        do_reset();
        repeat (255) step();
        check("wrap_cycle255", 64'(cycle), 64'd255);
        target_reset = 1'b0;
        step();
        check("wrap_cycle0", 64'(cycle), 64'd0);
        target_reset = 1'b1;
        step();
        check_evt("wrap_e0", 8'd255, 1'b0);
        evt_ready = 1'b1;
        step();
        check_evt("wrap_e1", 8'd0, 1'b1);
        step();
        check("wrap_empty", 64'(evt_valid), 64'd0);
        check("wrap_no_ovf", 64'(overflow), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
